// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready transmit stage.
//   tx_state_t  : transmit FSM state (IDLE = nothing presented, SEND = byte held on valid/data)
//   DATA_W_DEF  : default data path width
//   byte_t      : convenience byte type
package hs_pkg;

    typedef enum logic {IDLE, SEND} tx_state_t;

    localparam int DATA_W_DEF = 8;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO used as the producer-side buffer of hs_tx_stage.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers and level clear)
//   push        : write request; ignored while full
//   push_data   : byte written on an accepted push
//   pop         : read request; ignored while empty
//   head        : entry at the read pointer (valid while !empty)
//   level       : number of stored entries, 0..DEPTH
//   full, empty : occupancy flags derived from level
module hs_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Storage carries no reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/hs_tx_stage.sv
// Transmit stage: buffers producer bytes in hs_sync_fifo and presents them one
// at a time on a valid/data/ready handshake, holding valid/data until ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_data   : producer offer; accepted when in_ready is high
//   in_ready            : FIFO not full
//   valid, data, ready  : downstream handshake (registered valid/data)
//   level               : FIFO occupancy, not counting the output register
//   tx_count            : completed downstream transfers, wraps at 16 bits
//   timeout_err         : sticky flag, set after TIMEOUT stalled SEND cycles
module hs_tx_stage
    import hs_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     valid,
    output logic [DATA_W-1:0]        data,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              tx_count,
    output logic                     timeout_err
);

    localparam int WW = $clog2(TIMEOUT + 1);

    tx_state_t         state_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [15:0]       tx_count_q;
    logic [WW-1:0]     wait_q;
    logic              err_q;

    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pop;

    // Load the output register when it is empty (IDLE) or being emptied this
    // cycle by a completed transfer; the latter gives back-to-back bytes.
    assign pop = !empty && ((state_q == IDLE) || ready);

    hs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign in_ready    = !full;
    assign valid       = valid_q;
    assign data        = data_q;
    assign tx_count    = tx_count_q;
    assign timeout_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            tx_count_q <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_q <= '0;
                    if (!empty) begin
                        data_q  <= head;
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (ready) begin
                        tx_count_q <= tx_count_q + 16'd1;
                        wait_q     <= '0;
                        if (!empty) begin
                            data_q <= head;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (wait_q != WW'(TIMEOUT)) begin
                            wait_q <= wait_q + 1'b1;
                        end
                        // Flag rises on the same edge the stall count reaches TIMEOUT.
                        if (wait_q == WW'(TIMEOUT - 1)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
